// File: rtl/hazard_sequencer.sv
// Load-use / flag hazard stall and taken-branch flush sequencer for the 5-stage pipeline.
// Outputs are combinational from state and inputs; stall/flush perf counters saturate.
module hazard_sequencer #(
   parameter int unsigned LU_STALL_CYCLES = 1,
   parameter int unsigned BR_FLUSH_CYCLES = 1,
   parameter bit          FLAG_FWD        = 1'b1,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic             ID_rs1_used,
   input  logic             ID_rs2_used,
   input  logic             ID_is_bcond,
   input  logic             ID_BrTaken,
   input  logic             EX_MemRead,
   input  logic             EX_RegWrite,
   input  logic [4:0]       EX_Rd,
   input  logic             EX_SetFlag,
   output logic             PC_en,
   output logic             IF_ID_en,
   output logic             IF_ID_flush,
   output logic             ID_EX_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

   localparam logic [2:0] LU_REM = (LU_STALL_CYCLES > 1) ? 3'(LU_STALL_CYCLES - 2) : 3'd0;
   localparam logic [2:0] BR_REM = (BR_FLUSH_CYCLES > 1) ? 3'(BR_FLUSH_CYCLES - 2) : 3'd0;

   state_t           state_q, state_d;
   logic [2:0]       rem_q, rem_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             lu_haz, fl_haz;

   // X31 is XZR: writes to it are discarded, so it can never create a dependency.
   assign lu_haz = EX_MemRead & EX_RegWrite & (EX_Rd != 5'd31) &
                   ((ID_rs1_used & (ID_rs1 == EX_Rd)) | (ID_rs2_used & (ID_rs2 == EX_Rd)));
   assign fl_haz = (FLAG_FWD == 1'b0) & ID_is_bcond & EX_SetFlag;

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      PC_en        = 1'b1;
      IF_ID_en     = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b0;
      case (state_q)
         RUN: begin
            // A stall masks ID_BrTaken: the branch operand may be stale until the stall ends.
            if (lu_haz || fl_haz) begin
               PC_en        = 1'b0;
               IF_ID_en     = 1'b0;
               ID_EX_bubble = 1'b1;
               if (lu_haz && LU_STALL_CYCLES > 1) begin
                  state_d = LU_STALL;
                  rem_d   = LU_REM;
               end
            end else if (ID_BrTaken) begin
               IF_ID_flush = 1'b1;
               if (BR_FLUSH_CYCLES > 1) begin
                  state_d = FLUSH;
                  rem_d   = BR_REM;
               end
            end
         end
         LU_STALL: begin
            PC_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EX_bubble = 1'b1;
            if (rem_q == 3'd0) state_d = RUN;
            else               rem_d   = rem_q - 3'd1;
         end
         FLUSH: begin
            IF_ID_flush = 1'b1;
            if (rem_q == 3'd0) state_d = RUN;
            else               rem_d   = rem_q - 3'd1;
         end
         default: state_d = RUN;
      endcase
      if (reset) begin
         PC_en        = 1'b0;
         IF_ID_en     = 1'b0;
         IF_ID_flush  = 1'b1;
         ID_EX_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         rem_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         if (ID_EX_bubble && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (IF_ID_flush && flush_cnt_q != '1)  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
